// File: rtl/seq_alu.sv
// Multi-cycle execute unit: single-cycle logic/arith ops, iterative one-bit-per-clock shifts,
// valid/ready on both sides. Define SEQ_ALU_OVF_EN to add the signed-overflow output ovf.
module seq_alu #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         ALU,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               bad_op,
`ifdef SEQ_ALU_OVF_EN
    output logic               ovf,
`endif
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   result_q;
    logic               bad_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               left_q;

    logic [WIDTH-1:0]   op_res;
    logic               op_bad;
    logic               is_sll;
    logic               is_shift;
    logic [WIDTH-1:0]   first_shift;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;

    assign sum         = A + B;
    assign diff        = A - B;
    assign is_sll      = (ALU == 4'b0100);
    assign is_shift    = is_sll || (ALU == 4'b0101);
    assign first_shift = is_sll ? (B << 1) : (B >> 1);

    always_comb begin
        op_res = '0;
        op_bad = 1'b0;
        case (ALU)
            4'b0000: op_res = A & B;
            4'b0001: op_res = A | B;
            4'b0010: op_res = sum;
            4'b0011: op_res = A;
            4'b0100: op_res = B;
            4'b0101: op_res = B;
            4'b0110: op_res = diff;
            4'b0111: op_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'b1100: op_res = ~(A | B);
            default: op_bad = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_OVF_EN
    logic op_ovf;
    logic ovf_q;

    always_comb begin
        op_ovf = 1'b0;
        if (ALU == 4'b0010)
            op_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        else if (ALU == 4'b0110)
            op_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (reset)
            ovf_q <= 1'b0;
        else if (state_q == IDLE && in_valid)
            ovf_q <= op_ovf;
    end

    assign ovf = ovf_q;
`endif

    // The first shift step is taken on the accept edge so a shift of N finishes in N cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            bad_q    <= 1'b0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        bad_q  <= op_bad;
                        left_q <= is_sll;
                        if (is_shift && shamt != '0) begin
                            result_q <= first_shift;
                            cnt_q    <= shamt - SHAMT_W'(1);
                            state_q  <= (shamt == SHAMT_W'(1)) ? DONE : SHIFT;
                        end else begin
                            result_q <= op_res;
                            state_q  <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    result_q <= left_q ? (result_q << 1) : (result_q >> 1);
                    cnt_q    <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1))
                        state_q <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign bad_op    = bad_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed pins plus randomized ops against an arithmetic model.
module tb_seq_alu;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    ALU = '0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [SW-1:0] shamt = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  result;
    logic          zero;
    logic          bad_op;
    logic          out_valid;
    logic          out_ready = 1'b0;
`ifdef SEQ_ALU_OVF_EN
    logic          ovf;
`endif

    seq_alu #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ALU       (ALU),
        .A         (A),
        .B         (B),
        .shamt     (shamt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .zero      (zero),
        .bad_op    (bad_op),
`ifdef SEQ_ALU_OVF_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_res(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [SW-1:0] sh);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a;
            4'd4:  return b << sh;
            4'd5:  return b >> sh;
            4'd6:  return a - b;
            4'd7:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'd12: return ~(a | b);
            default: return '0;
        endcase
    endfunction

    function automatic logic model_bad(input logic [3:0] op);
        return !(op <= 4'd7 || op == 4'd12);
    endfunction

    function automatic logic model_ovf(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 4'd2)      r = sa + sb;
        else if (op == 4'd6) r = sa - sb;
        else                 return 1'b0;
        return (r > longint'(32'sh7FFF_FFFF)) || (r < -longint'(64'h8000_0000));
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [SW-1:0] sh);
        if ((op == 4'd4 || op == 4'd5) && sh != 0) return int'(sh);
        return 1;
    endfunction

    logic [W-1:0] exp_res = '0;
    logic         exp_bad = 1'b0;
    logic         exp_ovf = 1'b0;
    bit           exp_live = 1'b0;
    logic [W-1:0] last_res;
    logic         last_zero;
    logic         last_bad;
    logic         last_ovf;

    // Output checker: every cycle the result is presented it must match the model.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (!exp_live) begin
                check("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                check("result", 64'(result), 64'(exp_res));
                check("zero", 64'(zero), 64'(exp_res == '0));
                check("bad_op", 64'(bad_op), 64'(exp_bad));
`ifdef SEQ_ALU_OVF_EN
                check("ovf", 64'(ovf), 64'(exp_ovf));
`endif
                check("in_ready_in_done", 64'(in_ready), 64'd0);
            end
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [SW-1:0] sh, input int hold, input bit poke);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
        ALU = op; A = a; B = b; shamt = sh; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_res  = model_res(op, a, b, sh);
        exp_bad  = model_bad(op);
        exp_ovf  = model_ovf(op, a, b);
        exp_live = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid) check("in_ready_busy", 64'(in_ready), 64'd0);
        end while (!out_valid && lat < 100);
        check("latency", 64'(lat), 64'(model_lat(op, sh)));
        last_res  = result;
        last_zero = zero;
        last_bad  = bad_op;
`ifdef SEQ_ALU_OVF_EN
        last_ovf  = ovf;
`else
        last_ovf  = 1'b0;
`endif
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                ALU = 4'b0010; A = $urandom; B = $urandom; shamt = SW'($urandom); in_valid = 1'b1;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        exp_live  = 1'b0;
        @(negedge clk);
        check("out_valid_drop", 64'(out_valid), 64'd0);
        check("in_ready_after_release", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_zero", 64'(zero), 64'd1);
        check("rst_bad_op", 64'(bad_op), 64'd0);

        run_op(4'b0010, 32'd7, 32'd5, 5'd0, 0, 1'b0);
        check("pin_add", 64'(last_res), 64'd12);
        check("pin_add_zero", 64'(last_zero), 64'd0);
        run_op(4'b0110, 32'd5, 32'd5, 5'd0, 1, 1'b0);
        check("pin_sub", 64'(last_res), 64'd0);
        check("pin_sub_zero", 64'(last_zero), 64'd1);
        run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 0, 1'b0);
        check("pin_slt", 64'(last_res), 64'd1);
        run_op(4'b0100, 32'd0, 32'd1, 5'd4, 0, 1'b0);
        check("pin_sll4", 64'(last_res), 64'd16);
        run_op(4'b0101, 32'd0, 32'h8000_0000, 5'd31, 0, 1'b0);
        check("pin_srl31", 64'(last_res), 64'd1);
        run_op(4'b0100, 32'd0, 32'hA5, 5'd0, 0, 1'b0);
        check("pin_sll0", 64'(last_res), 64'hA5);
        run_op(4'b1010, 32'd3, 32'd4, 5'd0, 0, 1'b0);
        check("pin_bad_res", 64'(last_res), 64'd0);
        check("pin_bad_flag", 64'(last_bad), 64'd1);
        run_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 5, 1'b1);
        check("pin_and_held", 64'(last_res), 64'h00F0_1234);
`ifdef SEQ_ALU_OVF_EN
        run_op(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd0, 0, 1'b0);
        check("pin_add_ovf_res", 64'(last_res), 64'h8000_0000);
        check("pin_add_ovf", 64'(last_ovf), 64'd1);
        run_op(4'b0110, 32'h8000_0000, 32'd1, 5'd0, 0, 1'b0);
        check("pin_sub_ovf", 64'(last_ovf), 64'd1);
        run_op(4'b0000, 32'h7FFF_FFFF, 32'd1, 5'd0, 0, 1'b0);
        check("pin_and_ovf", 64'(last_ovf), 64'd0);
`endif

        // Reset during the second SHIFT cycle must drop the operation.
        ALU = 4'b0100; A = '0; B = 32'd1; shamt = 5'd10; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("shift_busy1", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("shift_busy2", 64'(in_ready), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_zero", 64'(zero), 64'd1);

        for (int k = 0; k < 250; k++) begin
            logic [3:0]    op;
            logic [W-1:0]  ra;
            logic [W-1:0]  rb;
            logic [SW-1:0] rs;
            op = 4'($urandom_range(0, 15));
            if (k % 4 == 0) op = (k % 8 == 0) ? 4'd4 : 4'd5;
            ra = $urandom;
            rb = $urandom;
            if (k % 5 == 0) rb = ra;
            if (k % 7 == 0) rb = ~ra + 1'b1;
            rs = SW'($urandom_range(0, 31));
            run_op(op, ra, rb, rs, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
